// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns HI/LO: shift-add multiply, restoring divide, one step per clock.
// Optional MULDIV_FASTZERO_EN: a multiply with a zero operand, or a divide by zero, skips RUN and finishes in one cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   opb;
    logic               is_div, neg_pq, neg_r, div_zero;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_signed, sa, sb, last, fast;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign is_signed = ~op[0];
    assign sa        = is_signed & srca[WIDTH-1];
    assign sb        = is_signed & srcb[WIDTH-1];
    assign mag_a     = sa ? -srca : srca;
    assign mag_b     = sb ? -srcb : srcb;
    assign last      = (count == CW'(WIDTH - 1));

`ifdef MULDIV_FASTZERO_EN
    assign fast = op[1] ? (srcb == '0) : ((srca == '0) || (srcb == '0));
`else
    assign fast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = fast ? DONE : RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    logic [WIDTH:0] sum, shifted, sub;
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
        sub     = shifted - {1'b0, opb};
        if (is_div) begin
            if (sub[WIDTH]) acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else            acc_nxt = {sub[WIDTH-1:0],     acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
    always_comb begin
        prod = neg_pq ? -acc_nxt : acc_nxt;
        quo  = neg_pq ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
        rem  = neg_r  ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res_hi = rem;
            res_lo = div_zero ? {WIDTH{1'b1}} : quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            neg_pq   <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mthi) hi_q <= wd;
                    if (mtlo) lo_q <= wd;
                    if (start) begin
                        count    <= '0;
                        is_div   <= op[1];
                        neg_pq   <= sa ^ sb;
                        neg_r    <= sa;
                        div_zero <= (srcb == '0);
                        if (op[1]) begin
                            acc <= {{WIDTH{1'b0}}, mag_a};
                            opb <= mag_b;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, mag_b};
                            opb <= mag_a;
                        end
                        // Fast path results override a move issued on the same edge.
                        if (fast) begin
                            if (op[1]) begin
                                hi_q <= srca;
                                lo_q <= {WIDTH{1'b1}};
                            end else begin
                                hi_q <= '0;
                                lo_q <= '0;
                            end
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    count <= count + CW'(1);
                    if (last) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the multi-cycle MIPS core, sitting beside the ALU in the datapath.
- Consumes operands from the A/B registers and a 2-bit op decoded by the controller. Owns the architectural HI/LO registers.
- Exposes busy/done so the main FSM can hold in a wait state until the result is ready.
- One iteration per clock: multiply is shift-add, divide is restoring.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; RUN phase lasts WIDTH cycles.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
srca  input  WIDTH  multiplicand / dividend
srcb  input  WIDTH  multiplier / divisor
mthi  input  1  write wd into HI (IDLE only)
mtlo  input  1  write wd into LO (IDLE only)
wd  input  WIDTH  write data for mthi/mtlo
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, high in DONE
hi  output  WIDTH  HI register, combinational read
lo  output  WIDTH  LO register, combinational read

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, named reset.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration count=0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge: latch op and operands, enter RUN with count=0.
  - Signed ops latch absolute values and record the result signs:
    - product sign = sa^sb
    - quotient sign = sa^sb
    - remainder sign = sa
- RUN:
  - busy=1; one iteration per cycle.
  - When count==WIDTH-1 at an edge: write final HI/LO, enter DONE.
  - Latency: start high in cycle 0 -> RUN in cycles 1..WIDTH -> DONE (done=1, busy=0) in cycle WIDTH+1 -> IDLE in WIDTH+2.
  - HI/LO hold their old values throughout RUN; they update only at the edge entering DONE.
- Multiply: {hi,lo} = full 2*WIDTH-bit product; signed ops apply two's-complement negation of the 2*WIDTH-bit magnitude.
- Divide: lo = quotient, hi = remainder, both with the signs above.
  - Signed INT_MIN / -1: lo=0x80000000, hi=0 (natural result of the magnitude algorithm).
  - Divisor zero: hi=srca (as latched, unsigned view), lo=all ones; normal latency unless MULDIV_FASTZERO_EN.
- start while in RUN or DONE: ignored, no queueing.
- mthi/mtlo:
  - Honoured only in IDLE; ignored in RUN/DONE.
  - Same edge as start: the move is written, then overwritten by the result at completion.
  - mthi and mtlo both high: both written.
- Reset mid-operation: abort immediately; all state returns to reset values and the partial result is discarded.
- Internal datapath: WIDTH+1-bit subtractor for the divide, 2*WIDTH-bit accumulator for the multiply; no combinational path from inputs to busy/done.

Optional Feature:
- Macro: MULDIV_FASTZERO_EN.
- Defined: at start in IDLE, if the op is a multiply with srca==0 or srcb==0, or a divide with srcb==0:
  - skip RUN and go IDLE -> DONE directly;
  - done=1 in cycle 1; busy never asserts;
  - results as specified: product 0; divide-by-zero hi=srca, lo=all ones.
- Undefined: every operation takes the full WIDTH-cycle RUN; results are identical.

Test Plan:
- MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF, start cycle 0 -> busy cycles 1..32, done cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT srca=0xFFFFFFFD (-3), srcb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); DIV srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIV srca=0x80000000, srcb=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> hi=5, lo=0xFFFFFFFF, done cycle 33 (cycle 1 with MULDIV_FASTZERO_EN).
- start pulsed again at cycle 10 during a MULTU 3*4 -> ignored; single done at cycle 33, lo=12, hi=0; mthi wd=0xAA at cycle 10 -> hi unchanged.
- reset asserted at cycle 15 of a DIVU -> cycle 16 state IDLE, busy=0, done=0, hi=lo=0; a new MULTU 2*3 then completes with lo=6 after 33 cycles.
- IDLE: mthi wd=0x1234 and mtlo wd=0x5678 in the same cycle -> next cycle hi=0x1234, lo=0x5678, busy=0, done=0.
